// File: rtl/mbus_rx_capture_fifo_pkg.sv
// Shared types for the MBus RX capture FIFO: the 72-bit entry layout and the
// handshake FSM state encodings.
package mbus_rx_capture_fifo_pkg;

  localparam int ENTRY_W = 72;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_FAILWAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  rsvd;
    logic        first;
    logic        last;
    logic        fail;
    logic        broadcast;
    logic [1:0]  control_bits;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  // Marker entry recorded when the bus reports a failure outside a request.
  function automatic entry_t fail_marker(input logic first);
    entry_t e;
    e       = '0;
    e.first = first;
    e.last  = 1'b1;
    e.fail  = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/mbus_rx_fifo_mem.sv
// DEPTH x 72 register array: one synchronous write port, one asynchronous
// read port.
module mbus_rx_fifo_mem
  import mbus_rx_capture_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int DEPTH      = 1 << DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  entry_t                wr_entry,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output entry_t                rd_entry
);

  entry_t mem_q [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the controller's
  // count, so stale contents are never presented as valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_entry;
  end

  assign rd_entry = mem_q[rd_addr];

endmodule

// File: rtl/mbus_rx_capture_fifo.sv
// MBus RX capture: acknowledges incoming words, tags frame/fail flags and
// queues them in a circular buffer for a valid/ready consumer.
module mbus_rx_capture_fifo
  import mbus_rx_capture_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int DEPTH      = 1 << DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mbus_rx_addr,
  input  logic [31:0] mbus_rx_data,
  input  logic        mbus_rx_req,
  input  logic        mbus_rx_pend,
  input  logic        mbus_rx_fail,
  input  logic        mbus_rx_broadcast,
  input  logic [1:0]  mbus_rx_control_bits,
  output logic        mbus_rx_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        out_fail,
  output logic        out_broadcast,
  output logic [1:0]  out_control_bits,
  output logic        stall
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  state_t                state_q, state_d;
  logic                  marker_pend_q, marker_pend_d;
  logic                  fail_q, frame_start_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  full, empty, push, push_marker, pop, fail_rise;
  entry_t                wr_entry, head;
  logic [1:0]            unused_rsvd;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign fail_rise = mbus_rx_fail & ~fail_q;
  assign pop       = out_ready & ~empty;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      marker_pend_q <= 1'b0;
      fail_q        <= 1'b0;
      frame_start_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      marker_pend_q <= marker_pend_d;
      fail_q        <= mbus_rx_fail;
      if (push) frame_start_q <= wr_entry.last;
    end
  end

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_d       = state_q;
    marker_pend_d = marker_pend_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mbus_rx_req) begin
          if (!full) state_d = ST_ACK;
        end else if (fail_rise) begin
          state_d       = ST_FAILWAIT;
          marker_pend_d = full;
        end
      end
      ST_ACK: if (!mbus_rx_req) state_d = ST_IDLE;
      ST_FAILWAIT: begin
        if (marker_pend_q && !full) marker_pend_d = 1'b0;
        if (!mbus_rx_fail && !marker_pend_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    push        = 1'b0;
    push_marker = 1'b0;
    stall       = 1'b0;
    mbus_rx_ack = (state_q == ST_ACK);
    unique case (state_q)
      ST_IDLE: begin
        if (mbus_rx_req) begin
          push  = !full;
          stall = full;
        end else if (fail_rise && !full) begin
          push        = 1'b1;
          push_marker = 1'b1;
        end
      end
      ST_FAILWAIT: begin
        push        = marker_pend_q && !full;
        push_marker = marker_pend_q && !full;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_entry              = '0;
    wr_entry.first        = frame_start_q;
    wr_entry.last         = ~mbus_rx_pend;
    wr_entry.fail         = mbus_rx_fail;
    wr_entry.broadcast    = mbus_rx_broadcast;
    wr_entry.control_bits = mbus_rx_control_bits;
    wr_entry.addr         = mbus_rx_addr;
    wr_entry.data         = mbus_rx_data;
    if (push_marker) wr_entry = fail_marker(frame_start_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
        default: ;
      endcase
    end
  end

  mbus_rx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk      (clk),
    .wr_en    (push),
    .wr_addr  (wr_ptr_q),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr_q),
    .rd_entry (head)
  );

  assign out_valid        = ~empty;
  assign out_addr         = head.addr;
  assign out_data         = head.data;
  assign out_first        = head.first;
  assign out_last         = head.last;
  assign out_fail         = head.fail;
  assign out_broadcast    = head.broadcast;
  assign out_control_bits = head.control_bits;
  assign unused_rsvd      = head.rsvd;

endmodule

// File: tb/tb_mbus_rx_capture_fifo.sv
// Scoreboard bench for mbus_rx_capture_fifo: stimulus queues expected entries,
// a negedge monitor compares every entry the consumer pops.
module tb_mbus_rx_capture_fifo;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        first;
    logic        last;
    logic        fail;
    logic        bcast;
    logic [1:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mbus_rx_addr, mbus_rx_data;
  logic        mbus_rx_req, mbus_rx_pend, mbus_rx_fail, mbus_rx_broadcast;
  logic [1:0]  mbus_rx_control_bits;
  logic        mbus_rx_ack, out_valid, out_ready;
  logic [31:0] out_addr, out_data;
  logic        out_first, out_last, out_fail, out_broadcast, stall;
  logic [1:0]  out_control_bits;

  exp_t exp_q[$];
  bit   fs_model;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop;

  always #5 clk = ~clk;

  mbus_rx_capture_fifo dut (
    .clk                  (clk),
    .reset                (reset),
    .mbus_rx_addr         (mbus_rx_addr),
    .mbus_rx_data         (mbus_rx_data),
    .mbus_rx_req          (mbus_rx_req),
    .mbus_rx_pend         (mbus_rx_pend),
    .mbus_rx_fail         (mbus_rx_fail),
    .mbus_rx_broadcast    (mbus_rx_broadcast),
    .mbus_rx_control_bits (mbus_rx_control_bits),
    .mbus_rx_ack          (mbus_rx_ack),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_addr             (out_addr),
    .out_data             (out_data),
    .out_first            (out_first),
    .out_last             (out_last),
    .out_fail             (out_fail),
    .out_broadcast        (out_broadcast),
    .out_control_bits     (out_control_bits),
    .stall                (stall)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the head is popped on the next posedge whenever valid && ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_entry: got addr=%0h data=%0h, expected none", out_addr, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("entry", {out_addr, out_data, out_first, out_last, out_fail, out_broadcast,
                        out_control_bits}, e);
      end
    end
  end

  function automatic exp_t word_exp(input logic [31:0] a, d, input logic pend, bc,
                                    input logic [1:0] ctrl);
    exp_t e;
    e = '{addr: a, data: d, first: fs_model, last: ~pend, fail: 1'b0, bcast: bc, ctrl: ctrl};
    return e;
  endfunction

  // Called at posedge+1; leaves at posedge+1 with the handshake finished.
  task automatic send_word(input logic [31:0] a, d, input logic pend, bc,
                           input logic [1:0] ctrl, input bit pop_same);
    exp_q.push_back(word_exp(a, d, pend, bc, ctrl));
    fs_model             = ~pend;
    mbus_rx_addr         = a;
    mbus_rx_data         = d;
    mbus_rx_pend         = pend;
    mbus_rx_broadcast    = bc;
    mbus_rx_control_bits = ctrl;
    mbus_rx_req          = 1'b1;
    if (pop_same) out_ready = 1'b1;
    @(posedge clk); #1;
    if (pop_same) out_ready = 1'b0;
    check("ack_rise", mbus_rx_ack, 1'b1);
    mbus_rx_req = 1'b0;
    @(posedge clk); #1;
    check("ack_fall", mbus_rx_ack, 1'b0);
  endtask

  // Pops everything with ready held high; n_pop counts entries drained.
  task automatic drain(input string name);
    n_pop     = 0;
    out_ready = 1'b1;
    while (out_valid && n_pop < 40) begin
      @(posedge clk); #1;
      n_pop++;
    end
    out_ready = 1'b0;
    check({name, "_sb_empty"}, exp_q.size(), 0);
    check({name, "_valid_low"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    mbus_rx_addr = '0; mbus_rx_data = '0; mbus_rx_req = 1'b0; mbus_rx_pend = 1'b0;
    mbus_rx_fail = 1'b0; mbus_rx_broadcast = 1'b0; mbus_rx_control_bits = '0;
    out_ready = 1'b0;
    fs_model  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", mbus_rx_ack, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_stall", stall, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single word, then read it back.
    send_word(32'h12, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 1'b0);
    check("single_valid", out_valid, 1'b1);
    drain("single");
    check("single_cnt", n_pop, 1);

    // Three-word message with the consumer always ready.
    out_ready = 1'b1;
    send_word(32'hA0, 32'h1111_0001, 1'b1, 1'b1, 2'b01, 1'b0);
    send_word(32'hA0, 32'h2222_0002, 1'b1, 1'b1, 2'b10, 1'b0);
    send_word(32'hA0, 32'h3333_0003, 1'b0, 1'b1, 2'b11, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("msg3_sb_empty", exp_q.size(), 0);

    // Fill to 8, then a 9th request is stalled until one pop.
    for (int i = 0; i < 8; i++)
      send_word(32'h100 + i, 32'hF000_0000 + i, 1'b0, 1'b0, 2'(i), 1'b0);
    exp_q.push_back(word_exp(32'h108, 32'hF000_0008, 1'b0, 1'b0, 2'b00));
    fs_model = 1'b1;
    mbus_rx_addr = 32'h108; mbus_rx_data = 32'hF000_0008; mbus_rx_pend = 1'b0;
    mbus_rx_control_bits = 2'b00; mbus_rx_req = 1'b1;
    #1;
    check("full_stall", stall, 1'b1);
    check("full_no_ack", mbus_rx_ack, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("full_pop_no_ack", mbus_rx_ack, 1'b0);
    check("full_stall_clear", stall, 1'b0);
    @(posedge clk); #1;
    check("full_ack_9th", mbus_rx_ack, 1'b1);
    mbus_rx_req = 1'b0;
    @(posedge clk); #1;
    check("full_ack_fall", mbus_rx_ack, 1'b0);
    drain("full");
    check("full_cnt", n_pop, 8);

    // Standalone fail pulse: marker entry, no ack.
    exp_q.push_back('{addr: '0, data: '0, first: fs_model, last: 1'b1, fail: 1'b1,
                      bcast: 1'b0, ctrl: 2'b00});
    fs_model     = 1'b1;
    mbus_rx_fail = 1'b1;
    @(posedge clk); #1;
    check("fail_no_ack0", mbus_rx_ack, 1'b0);
    check("fail_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    check("fail_no_ack1", mbus_rx_ack, 1'b0);
    mbus_rx_fail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("fail_no_ack2", mbus_rx_ack, 1'b0);
    send_word(32'h55, 32'hCAFE_F00D, 1'b0, 1'b0, 2'b00, 1'b0);
    drain("fail");
    check("fail_cnt", n_pop, 2);

    // Steady state at 4 entries: push and pop together, pointers wrap.
    for (int i = 0; i < 4; i++)
      send_word(32'h200 + i, 32'h0 + i, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 4; i < 24; i++)
      send_word(32'h200 + i, 32'h0 + i, 1'b0, 1'b0, 2'b01, 1'b1);
    drain("wrap");
    check("wrap_cnt", n_pop, 4);

    // Reset in the middle of a handshake with 3 entries stored.
    send_word(32'h300, 32'h7000_0001, 1'b1, 1'b0, 2'b00, 1'b0);
    send_word(32'h301, 32'h7000_0002, 1'b1, 1'b0, 2'b00, 1'b0);
    mbus_rx_addr = 32'h302; mbus_rx_data = 32'h7000_0003; mbus_rx_pend = 1'b1;
    mbus_rx_req  = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack_hi", mbus_rx_ack, 1'b1);
    #2;
    reset = 1'b1;
    mbus_rx_req = 1'b0;
    #1;
    check("rst_mid_ack", mbus_rx_ack, 1'b0);
    check("rst_mid_valid", out_valid, 1'b0);
    exp_q.delete();
    fs_model = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_word(32'h400, 32'h8000_0001, 1'b0, 1'b0, 2'b00, 1'b0);
    drain("post_rst");
    check("post_rst_cnt", n_pop, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mbus_rx_capture_fifo.md
MBUS_RX_CAPTURE_FIFO -- requirements
Module: mbus_rx_capture_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, log2 of entry count.
REQ-002 SHALL have parameter DEPTH, default 1<<DEPTH_LOG2, entry count.
REQ-003 clk  in  1  system clock; every flop is on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 mbus_rx_addr  in  32  MBus RX address, valid while mbus_rx_req is high.
REQ-006 mbus_rx_data  in  32  MBus RX data word, valid while mbus_rx_req is high.
REQ-007 mbus_rx_req  in  1  RX request, already double-latched into the clk domain.
REQ-008 mbus_rx_pend  in  1  more words follow (double-latched).
REQ-009 mbus_rx_fail  in  1  RX failure (double-latched).
REQ-010 mbus_rx_broadcast  in  1  broadcast flag.
REQ-011 mbus_rx_control_bits  in  2  MBus control bits.
REQ-012 mbus_rx_ack  out  1  RX acknowledge back to the MBus controller.
REQ-013 out_valid  out  1  head entry available.
REQ-014 out_ready  in  1  consumer pops the head when high together with out_valid.
REQ-015 out_addr / out_data  out  32/32  head entry address and data.
REQ-016 out_first / out_last / out_fail / out_broadcast  out  1 each  head entry flags.
REQ-017 out_control_bits  out  2  head entry control bits.
REQ-018 stall  out  1  high while a request is held off because the FIFO is full.

Function
REQ-019 Handshake FSM SHALL have states IDLE, ACK and FAILWAIT.
REQ-020 IDLE: if mbus_rx_req=1 and the FIFO is not full, SHALL push one entry and go to ACK; mbus_rx_ack is registered high on the next edge.
REQ-021 IDLE with mbus_rx_req=1 and the FIFO full SHALL push nothing, hold mbus_rx_ack low and assert stall.
REQ-022 ACK: mbus_rx_ack SHALL stay high until mbus_rx_req is sampled low, then drop on the next edge, with the FSM returning to IDLE.
REQ-023 A pushed entry SHALL contain addr, data, broadcast, control_bits, fail=mbus_rx_fail, last=~mbus_rx_pend, and first=frame_start.
REQ-024 frame_start SHALL be 1 after reset and after any entry pushed with last=1, and 0 after any entry pushed with last=0.
REQ-025 A rising edge of mbus_rx_fail in IDLE with mbus_rx_req=0 SHALL push a marker entry (fail=1, last=1, first=frame_start, addr=0, data=0) without asserting mbus_rx_ack, then go to FAILWAIT.
REQ-026 If the FIFO is full at that edge, the marker SHALL be pushed on the first cycle the FIFO is not full.
REQ-027 FAILWAIT SHALL return to IDLE when mbus_rx_fail is sampled low.
REQ-028 Storage SHALL be a circular buffer:
  - read pointer wr_ptr/rd_ptr are DEPTH_LOG2 bits and wrap modulo DEPTH;
  - count is DEPTH_LOG2+1 bits;
  - full is count==DEPTH; empty is count==0.
REQ-029 out_valid SHALL equal ~empty; the head fields SHALL be presented combinationally from rd_ptr.
REQ-030 Write-to-out_valid latency SHALL be 1 cycle (valid on the edge after the push).
REQ-031 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-032 A pop when empty and a push when full SHALL be ignored and SHALL NOT move any pointer.
REQ-033 Full SHALL be evaluated from the registered count; a same-cycle pop SHALL NOT admit a push.
REQ-034 The output head fields are don't-care when out_valid=0.

Reset
REQ-035 Reset SHALL set: FSM=IDLE, pointers=0, count=0, frame_start=1, fail-edge register=0.
REQ-036 Reset SHALL drive outputs: mbus_rx_ack=0, out_valid=0, stall=0.
REQ-037 Reset asserted mid-handshake SHALL immediately drop mbus_rx_ack and discard all stored entries.
REQ-038 Storage array contents SHALL NOT need reset.

Structure
REQ-039 The entry bit layout (72 bits) and the FSM state encodings SHALL live in a shared include alongside ice_def.v.
REQ-040 A single sub-module, mbus_rx_fifo_mem (DEPTH x 72 register array, one write port and one asynchronous read port), SHALL hold the storage.

Verification
REQ-041 Single word: req=1 with addr=0x12, data=0xDEADBEEF, pend=0 -> ack=1 one cycle later, out_valid=1, first=1, last=1, fail=0; req=0 -> ack=0 the next cycle.
REQ-042 Three-word message (pend=1,1,0), consumer ready -> entries flagged first=1,0,0 and last=0,0,1 with data matching in order.
REQ-043 out_ready=0 while 9 words are sent with DEPTH=8 -> 8 entries accepted; 9th req sees ack=0 and stall=1; one pop -> 9th word accepted next cycle and stall=0.
REQ-044 Standalone fail pulse with req=0 -> one entry with fail=1, last=1, data=0, and no ack; the next word has first=1.
REQ-045 Simultaneous push and pop at count=4 -> count stays 4; pointers wrap from 7 to 0 correctly over 20 words.
REQ-046 Reset asserted while ack=1 with 3 entries stored -> ack=0 and out_valid=0 immediately; the next word is first=1.
